// File: rtl/phase_accum_mc.sv
// Multi-channel phase accumulator. Each channel has a saw or ping-pong address sweep, an offset,
// and a double-buffered increment that is committed at the period boundary.
module phase_accum_mc #(
    parameter int WIDTH     = 9,
    parameter int CHANNELS  = 2,
    parameter int INIT_INCR = 1,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      sync,
    input  logic                      wr_en,
    input  logic [CW-1:0]             wr_ch,
    input  logic [1:0]                wr_sel,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [CHANNELS*WIDTH-1:0] addr,
    output logic [CHANNELS-1:0]       wrap
);

    localparam logic [WIDTH-1:0] INCR0   = WIDTH'(INIT_INCR);
    // Low WIDTH bits of 2*MAX; the top reflection result always fits in WIDTH bits.
    localparam logic [WIDTH-1:0] TWO_MAX = {WIDTH{1'b1}} << 1;

    logic [WIDTH-1:0] phase_q    [CHANNELS];
    logic [WIDTH-1:0] phase_d    [CHANNELS];
    logic [WIDTH-1:0] incr_act_q [CHANNELS];
    logic [WIDTH-1:0] incr_act_d [CHANNELS];
    logic [WIDTH-1:0] incr_shd_q [CHANNELS];
    logic [WIDTH-1:0] incr_shd_d [CHANNELS];
    logic [WIDTH-1:0] offset_q   [CHANNELS];
    logic [WIDTH-1:0] offset_d   [CHANNELS];
    logic [WIDTH-1:0] addr_d     [CHANNELS];
    logic [WIDTH:0]   sum        [CHANNELS];
    logic [CHANNELS-1:0] dir_q, dir_d;      // 0 = up, 1 = down
    logic [CHANNELS-1:0] mode_q, mode_d;    // 0 = saw, 1 = ping-pong
    logic [CHANNELS-1:0] wrap_d;
    logic [CHANNELS-1:0] wr_hit;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            wr_hit[c]     = wr_en && (int'(wr_ch) == c);
            sum[c]        = {1'b0, phase_q[c]} + {1'b0, incr_act_q[c]};
            phase_d[c]    = phase_q[c];
            dir_d[c]      = dir_q[c];
            incr_act_d[c] = incr_act_q[c];
            incr_shd_d[c] = incr_shd_q[c];
            offset_d[c]   = offset_q[c];
            mode_d[c]     = mode_q[c];
            wrap_d[c]     = 1'b0;

            if (sync) begin
                phase_d[c]    = '0;
                dir_d[c]      = 1'b0;
                incr_act_d[c] = incr_shd_q[c];
            end else if (en) begin
                if (!mode_q[c]) begin
                    phase_d[c] = sum[c][WIDTH-1:0];
                    wrap_d[c]  = sum[c][WIDTH];
                end else if (!dir_q[c]) begin
                    if (sum[c][WIDTH]) begin
                        phase_d[c] = TWO_MAX - sum[c][WIDTH-1:0];
                        dir_d[c]   = 1'b1;
                    end else begin
                        phase_d[c] = sum[c][WIDTH-1:0];
                    end
                end else if (phase_q[c] < incr_act_q[c]) begin
                    phase_d[c] = incr_act_q[c] - phase_q[c];
                    dir_d[c]   = 1'b0;
                    wrap_d[c]  = 1'b1;
                end else begin
                    phase_d[c] = phase_q[c] - incr_act_q[c];
                end
                if (wrap_d[c]) begin
                    incr_act_d[c] = incr_shd_q[c];
                end
            end

            // Register writes use pre-edge state, so a shadow write on a wrap edge waits a period.
            if (wr_hit[c]) begin
                case (wr_sel)
                    2'b00: incr_shd_d[c] = wr_data;
                    2'b01: offset_d[c]   = wr_data;
                    2'b10: begin
                        mode_d[c] = wr_data[0];
                        if (!wr_data[0]) begin
                            dir_d[c] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            addr_d[c] = phase_d[c] + offset_d[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                phase_q[c]    <= '0;
                incr_act_q[c] <= INCR0;
                incr_shd_q[c] <= INCR0;
                offset_q[c]   <= '0;
            end
            dir_q  <= '0;
            mode_q <= '0;
            addr   <= '0;
            wrap   <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                phase_q[c]                <= phase_d[c];
                incr_act_q[c]             <= incr_act_d[c];
                incr_shd_q[c]             <= incr_shd_d[c];
                offset_q[c]               <= offset_d[c];
                addr[c*WIDTH +: WIDTH]    <= addr_d[c];
            end
            dir_q  <= dir_d;
            mode_q <= mode_d;
            wrap   <= wrap_d;
        end
    end

endmodule

// File: doc/phase_accum_mc.md
# phase_accum_mc

Multi-channel phase accumulator for the signal-generator datapath. It produces CHANNELS independent WIDTH-bit ROM addresses, each with its own increment, phase offset and waveform-address mode (sawtooth wrap or ping-pong reflect). Increment changes are double-buffered and committed only at a period boundary, so frequency changes never glitch mid-cycle. It sits between the control/register logic and the per-channel waveform ROMs.

## Interface

**Parameters**
- WIDTH, default 9: accumulator and address width. MAX = 2^WIDTH−1.
- CHANNELS, default 2: number of independent channels (≥1).
- INIT_INCR, default 1: reset value of the active and shadow increment for every channel.

**Ports** (CW = max(1, clog2(CHANNELS)))
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- en, input, 1: global advance enable.
- sync, input, 1: synchronous restart of all channels.
- wr_en, input, 1: register write strobe.
- wr_ch, input, CW: target channel.
- wr_sel, input, 2: target register. 00 = incr shadow, 01 = offset, 10 = mode (wr_data[0]), 11 = ignored.
- wr_data, input, WIDTH: write data.
- addr, output, CHANNELS*WIDTH: per-channel address; channel c occupies bits [c*WIDTH +: WIDTH].
- wrap, output, CHANNELS: per-channel one-cycle period-boundary pulse.

## Operation

- Per-channel state: phase, dir (up/down), incr_act, incr_shd, offset, mode (0 = saw, 1 = ping-pong).
- Reset (async): phase = 0, dir = up, incr_act = incr_shd = INIT_INCR, offset = 0, mode = saw, addr = 0, wrap = 0.
- Priority per edge: rst > sync > en advance. Writes are independent of en and sync.
- Sync: phase ← 0, dir ← up, incr_act ← incr_shd (pre-edge value), wrap ← 0.
- en = 0: phase, dir and incr_act hold; wrap = 0.
- Saw advance: s = phase + incr_act (WIDTH+1 bits). phase ← s mod 2^WIDTH. wrap ← s[WIDTH] (carry out).
- Ping-pong, up: if phase + incr_act > MAX, then phase ← 2·MAX − phase − incr_act and dir ← down; else phase ← phase + incr_act.
- Ping-pong, down: if phase < incr_act, then phase ← incr_act − phase, dir ← up, and wrap ← 1; else phase ← phase − incr_act.
- Only the bottom reflection pulses wrap; the top reflection does not.
- Commit: on any cycle where a channel's wrap is set, incr_act ← incr_shd (pre-edge value). incr_shd is otherwise invisible to the datapath.
- incr_act = 0: phase holds and no wrap occurs.
- Writes:
  - Applied at the edge when wr_en = 1.
  - wr_ch ≥ CHANNELS is ignored.
  - An offset write is visible in addr the next cycle.
  - A mode write takes effect on the next advance; writing saw forces dir ← up.
- A write to incr_shd on the same edge as a wrap on that channel: incr_act takes the old shadow value and the new value waits for the next wrap.
- addr is registered: addr ← (phase_next + offset_next) mod 2^WIDTH. addr therefore always equals phase + offset with no extra lag.

## Timing

- Advance latency: addr reflects a new phase one cycle after the en = 1 edge.
- wrap is registered and coincident with the first addr value of the new period.
- Increment commit: the new incr_act applies to the advance on the edge after the wrap pulse.
- Sync: addr = offset and wrap = 0 in the cycle after sync is sampled.
- rst mid-operation: all outputs 0 immediately (asynchronous); all shadow, offset and mode writes are lost.
- No combinational paths from input to output.

## Test plan

- Reset/default, WIDTH=4, INIT_INCR=1, en=1 → ch0 addr 0,1,…,15,0; wrap high only in the cycle addr returns to 0; all channels identical.
- Saw, ch0 incr 5 (write, then sync) → addr 0,5,10,15,4(wrap),9,14,3(wrap); ch1 unaffected at incr 1.
- Ping-pong, ch1 mode=1, incr 6, sync → addr 0,6,12,12,6,0,6(wrap),12; wrap pulses only at the 0→6 reflection.
- Shadow commit: saw incr 4; write incr 3 when addr = 8 → sequence 8,12,0(wrap),3,6…; same-edge write at wrap defers to the next wrap.
- Offset/en: offset 7, incr 2 → addr 7,9,11…; en=0 for 3 cycles holds addr and wrap stays 0; offset write during hold updates addr the next cycle.
- Reset/sync mid-run: assert rst asynchronously mid-period → addr=0 and wrap=0 immediately, INIT_INCR restored; sync with a pending shadow value → phase 0 and the shadow increment in use on the next advance.
